// File: rtl/vram_pkg.sv
// Shared constants and scroll-state encoding for the text-VRAM scheduler.
package vram_pkg;

  localparam int         COLS       = 80;
  localparam int         ROWS       = 30;
  localparam int         CELLS      = COLS * ROWS;
  localparam int         COPY_CELLS = COLS * (ROWS - 1);
  localparam logic [7:0] FILL_CHAR  = 8'h20;
  localparam int         VRAM_AW    = 20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COPY_RD = 3'd1,
    COPY_WR = 3'd2,
    FILL    = 3'd3,
    DONE    = 3'd4
  } scroll_state_t;

endpackage

// File: rtl/vram_scroll_engine.sv
// Scroll-up engine: copies rows 1..ROWS-1 up one row, then blanks the last row.
// Issues one RAM request per cycle; a refused slot leaves state and idx untouched.
module vram_scroll_engine
  import vram_pkg::*;
#(
  parameter int         N_COLS   = COLS,
  parameter int         N_ROWS   = ROWS,
  parameter int         ADDR_W   = VRAM_AW,
  parameter logic [7:0] FILL_VAL = FILL_CHAR
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              start,
  input  logic              granted,
  input  logic [7:0]        rdata,
  output logic              req,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wdata,
  output logic              busy,
  output logic              done
);

  localparam int N_CELLS = N_COLS * N_ROWS;
  localparam int N_COPY  = N_COLS * (N_ROWS - 1);
  localparam int IDX_W   = $clog2(N_CELLS);

  localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] ROW_STEP   = IDX_W'(N_COLS);
  localparam logic [IDX_W-1:0] LAST_COPY  = IDX_W'(N_COPY - 1);
  localparam logic [IDX_W-1:0] FIRST_FILL = IDX_W'(N_COPY);
  localparam logic [IDX_W-1:0] LAST_FILL  = IDX_W'(N_CELLS - 1);

  scroll_state_t    state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [7:0]       hold_r;
  logic             rd_done_r;

  // rd_done_r marks the cycle in which this engine's read data sits on rdata
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r   <= IDLE;
      idx_r     <= IDX_ZERO;
      hold_r    <= 8'h00;
      rd_done_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      rd_done_r <= granted && (state_r == COPY_RD);
      if (rd_done_r) begin
        hold_r <= rdata;
      end
    end
  end

  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = COPY_RD;
          idx_s   = IDX_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      COPY_RD: begin
        if (granted) begin
          state_s = COPY_WR;
        end else begin
          state_s = COPY_RD;
        end
      end
      COPY_WR: begin
        if (!granted) begin
          state_s = COPY_WR;
        end else if (idx_r == LAST_COPY) begin
          state_s = FILL;
          idx_s   = FIRST_FILL;
        end else begin
          state_s = COPY_RD;
          idx_s   = idx_r + IDX_ONE;
        end
      end
      FILL: begin
        if (!granted) begin
          state_s = FILL;
        end else if (idx_r == LAST_FILL) begin
          state_s = DONE;
          idx_s   = IDX_ZERO;
        end else begin
          state_s = FILL;
          idx_s   = idx_r + IDX_ONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // A write slot stolen right after the read falls back to the hold register
  always_comb begin
    req   = 1'b0;
    we    = 1'b0;
    addr  = {ADDR_W{1'b0}};
    wdata = 8'h00;
    case (state_r)
      COPY_RD: begin
        req  = 1'b1;
        addr = ADDR_W'(idx_r + ROW_STEP);
      end
      COPY_WR: begin
        req  = 1'b1;
        we   = 1'b1;
        addr = ADDR_W'(idx_r);
        if (rd_done_r) begin
          wdata = rdata;
        end else begin
          wdata = hold_r;
        end
      end
      FILL: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = ADDR_W'(idx_r);
        wdata = FILL_VAL;
      end
      default: begin
        req = 1'b0;
      end
    endcase
  end

  assign busy = (state_r == COPY_RD) || (state_r == COPY_WR) || (state_r == FILL);
  assign done = (state_r == DONE);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port text-VRAM scheduler: scan path > scroll engine > CPU, one grant per cycle.
// The RAM has one cycle of read latency; address/we/wdata are combinational from the grant.
module vram_arbiter #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter int         AW        = 20,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic          clk_25mhz,
  input  logic          clrn,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic [7:0]    scan_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  input  logic          scroll_start,
  output logic          scroll_busy,
  output logic          scroll_done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);

  localparam int CELLS = COLS * ROWS;

  logic          eng_req_s;
  logic          eng_we_s;
  logic          eng_granted_s;
  logic [AW-1:0] eng_addr_s;
  logic [7:0]    eng_wdata_s;
  logic          cpu_in_range_s;
  logic          cpu_grant_s;
  logic          cpu_ack_r;
  logic          cpu_rd_r;
  logic          scan_pend_r;
  logic [7:0]    scan_data_r;

  assign cpu_in_range_s = (cpu_addr < AW'(CELLS));
  assign eng_granted_s  = eng_req_s & ~scan_req;
  // The ack cycle is never a grant cycle, so back-to-back requests take two cycles each
  assign cpu_grant_s    = cpu_req & ~scan_req & ~scroll_busy & ~cpu_ack_r;

  vram_scroll_engine #(
    .N_COLS   (COLS),
    .N_ROWS   (ROWS),
    .ADDR_W   (AW),
    .FILL_VAL (FILL_CHAR)
  ) u_scroll (
    .clk     (clk_25mhz),
    .clrn    (clrn),
    .start   (scroll_start),
    .granted (eng_granted_s),
    .rdata   (ram_rdata),
    .req     (eng_req_s),
    .we      (eng_we_s),
    .addr    (eng_addr_s),
    .wdata   (eng_wdata_s),
    .busy    (scroll_busy),
    .done    (scroll_done)
  );

  // RAM port is held quiet while clrn is low, whatever the requesters do
  always_comb begin
    ram_addr  = {AW{1'b0}};
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (!clrn) begin
      ram_we = 1'b0;
    end else if (scan_req) begin
      ram_addr = scan_addr;
    end else if (eng_req_s) begin
      ram_addr  = eng_addr_s;
      ram_we    = eng_we_s;
      ram_wdata = eng_wdata_s;
    end else if (cpu_grant_s && cpu_in_range_s) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      if (cpu_we) begin
        ram_wdata = cpu_wdata;
      end else begin
        ram_wdata = 8'h00;
      end
    end else begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk_25mhz or negedge clrn) begin
    if (!clrn) begin
      cpu_ack_r   <= 1'b0;
      cpu_rd_r    <= 1'b0;
      scan_pend_r <= 1'b0;
      scan_data_r <= 8'h00;
    end else begin
      cpu_ack_r   <= cpu_grant_s;
      cpu_rd_r    <= cpu_grant_s && !cpu_we && cpu_in_range_s;
      scan_pend_r <= scan_req;
      if (scan_pend_r) begin
        scan_data_r <= ram_rdata;
      end
    end
  end

  // Read data arrives from the RAM in the ack cycle itself; out-of-range reads return zero
  always_comb begin
    if (cpu_ack_r && cpu_rd_r) begin
      cpu_rdata = ram_rdata;
    end else begin
      cpu_rdata = 8'h00;
    end
  end

  assign cpu_ack   = cpu_ack_r;
  assign scan_data = scan_data_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 4K x 8 synchronous RAM.
module tb_vram_arbiter;

  localparam int AW = 20;

  logic          clk_25mhz = 1'b0;
  logic          clrn;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic [7:0]    scan_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          scroll_start;
  logic          scroll_busy;
  logic          scroll_done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  logic [7:0] mem  [0:4095];
  logic [7:0] snap [0:4095];
  logic [1:0] load_cmd;
  int         wr_cnt = 0;
  int         n_cmp  = 0;
  int         n_err  = 0;

  typedef struct {
    logic          sreq;
    logic [AW-1:0] saddr;
    logic          creq;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [7:0]    cwd;
    logic          chk_addr;
    logic [AW-1:0] eaddr;
    logic          ewe;
    logic [7:0]    ewd;
    logic          eack;
  } vec_t;

  vec_t vecs [0:8];

  always #20 clk_25mhz = ~clk_25mhz;

  // load_cmd: 1 = cell i holds i[7:0], 2 = cell holds its row number, 3 = poke cell 0
  always @(posedge clk_25mhz) begin
    if (load_cmd == 2'd1) begin
      for (int i = 0; i < 4096; i++) mem[i] = (i < 2400) ? 8'(i) : 8'h00;
    end else if (load_cmd == 2'd2) begin
      for (int i = 0; i < 4096; i++) mem[i] = (i < 2400) ? 8'(i / 80) : 8'h00;
    end else if (load_cmd == 2'd3) begin
      mem[0] = 8'hC3;
    end else if (ram_addr < 20'd4096) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] = ram_wdata;
    end else begin
      ram_rdata <= 8'h00;
    end
  end

  always @(posedge clk_25mhz) begin
    if (ram_we) wr_cnt <= wr_cnt + 1;
  end

  vram_arbiter #(
    .COLS      (80),
    .ROWS      (30),
    .AW        (AW),
    .FILL_CHAR (8'h20)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .clrn         (clrn),
    .scan_req     (scan_req),
    .scan_addr    (scan_addr),
    .scan_data    (scan_data),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .scroll_start (scroll_start),
    .scroll_busy  (scroll_busy),
    .scroll_done  (scroll_done),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    scan_req     = 1'b0;
    scan_addr    = 20'd0;
    cpu_req      = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr     = 20'd0;
    cpu_wdata    = 8'h00;
    scroll_start = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] cmd);
    load_cmd = cmd;
    tick();
    load_cmd = 2'd0;
  endtask

  task automatic take_snap();
    for (int i = 0; i < 4096; i++) snap[i] = mem[i];
  endtask

  task automatic check_image(input string nm);
    int         bad;
    logic [7:0] e;
    bad = 0;
    for (int i = 0; i < 2400; i++) begin
      e = (i < 2320) ? snap[i + 80] : 8'h20;
      if (mem[i] !== e) bad++;
    end
    chk({nm, " bad cells"}, 32'(bad), 32'd0);
  endtask

  // Runs from the first busy cycle until busy falls; returns in the first non-busy cycle
  task automatic watch_scroll(input bit with_scan, output int busy_cycles,
                              output int stolen, output int acks);
    int cyc;
    cyc = 0;
    busy_cycles = 0;
    stolen = 0;
    acks = 0;
    while (scroll_busy && cyc < 10000) begin
      scan_req  = with_scan && (cyc % 8 == 0);
      scan_addr = 20'(cyc % 2400);
      if (scan_req) stolen++;
      busy_cycles++;
      tick();
      cyc++;
      if (cpu_ack) acks++;
    end
    scan_req  = 1'b0;
    scan_addr = 20'd0;
  endtask

  initial begin
    int bc, st, ak, w0;

    idle_inputs();
    clrn      = 1'b0;
    load_cmd  = 2'd1;
    scan_req  = 1'b1;
    scan_addr = 20'd5;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 20'd7;
    cpu_wdata = 8'h99;
    #3;
    chk("rst ram_addr", 32'(ram_addr), 32'd0);
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst scan_data", 32'(scan_data), 32'd0);
    chk("rst cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst busy", 32'(scroll_busy), 32'd0);
    chk("rst done", 32'(scroll_done), 32'd0);
    repeat (2) @(posedge clk_25mhz);
    #1;
    load_cmd = 2'd0;
    idle_inputs();
    @(negedge clk_25mhz);
    clrn = 1'b1;
    tick();

    // Scan only: one request every 8 cycles, data two edges later
    w0 = wr_cnt;
    for (int i = 0; i < 80; i++) begin
      scan_req  = 1'b1;
      scan_addr = 20'(i);
      tick();
      scan_req = 1'b0;
      tick();
      chk("scan data", 32'(scan_data), 32'(i));
      repeat (6) tick();
    end
    chk("scan hold", 32'(scan_data), 32'd79);
    chk("scan no writes", 32'(wr_cnt - w0), 32'd0);

    vecs[0] = '{1'b0, 20'd0,    1'b0, 1'b0, 20'd0,    8'h00, 1'b1, 20'd0,    1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 20'd37,   1'b0, 1'b0, 20'd0,    8'h00, 1'b1, 20'd37,   1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 20'd0,    1'b1, 1'b1, 20'd300,  8'h7E, 1'b1, 20'd300,  1'b1, 8'h7E, 1'b1};
    vecs[3] = '{1'b0, 20'd0,    1'b1, 1'b0, 20'd2399, 8'h00, 1'b1, 20'd2399, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 20'd1000, 1'b1, 1'b1, 20'd500,  8'h11, 1'b1, 20'd1000, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 20'd0,    1'b1, 1'b1, 20'd2400, 8'hAA, 1'b0, 20'd0,    1'b0, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 20'd0,    1'b1, 1'b1, 20'd2399, 8'h5C, 1'b1, 20'd2399, 1'b1, 8'h5C, 1'b1};
    vecs[7] = '{1'b1, 20'd2399, 1'b1, 1'b0, 20'd3,    8'h00, 1'b1, 20'd2399, 1'b0, 8'h00, 1'b0};
    vecs[8] = '{1'b0, 20'd0,    1'b1, 1'b0, 20'd4095, 8'h00, 1'b0, 20'd0,    1'b0, 8'h00, 1'b1};
    for (int k = 0; k < 9; k++) begin
      scan_req  = vecs[k].sreq;
      scan_addr = vecs[k].saddr;
      cpu_req   = vecs[k].creq;
      cpu_we    = vecs[k].cwe;
      cpu_addr  = vecs[k].caddr;
      cpu_wdata = vecs[k].cwd;
      @(negedge clk_25mhz);
      if (vecs[k].chk_addr) chk($sformatf("vec%0d ram_addr", k), 32'(ram_addr), 32'(vecs[k].eaddr));
      chk($sformatf("vec%0d ram_we", k), 32'(ram_we), 32'(vecs[k].ewe));
      if (vecs[k].ewe) chk($sformatf("vec%0d ram_wdata", k), 32'(ram_wdata), 32'(vecs[k].ewd));
      tick();
      idle_inputs();
      chk($sformatf("vec%0d cpu_ack", k), 32'(cpu_ack), 32'(vecs[k].eack));
      tick();
    end
    chk("vec mem[300]", 32'(mem[300]), 32'h7E);
    chk("vec mem[2399]", 32'(mem[2399]), 32'h5C);

    // CPU write with request held through the ack cycle: no regrant there
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00095; cpu_wdata = 8'h41;
    @(negedge clk_25mhz);
    chk("wr grant we", 32'(ram_we), 32'd1);
    chk("wr grant addr", 32'(ram_addr), 32'h95);
    tick();
    chk("wr ack", 32'(cpu_ack), 32'd1);
    @(negedge clk_25mhz);
    chk("wr ack-cycle regrant", 32'(ram_we), 32'd0);
    tick();
    idle_inputs();
    chk("wr ack one pulse", 32'(cpu_ack), 32'd0);
    chk("wr mem", 32'(mem[149]), 32'h41);

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00095;
    tick();
    cpu_req = 1'b0;
    chk("rd ack", 32'(cpu_ack), 32'd1);
    chk("rd data", 32'(cpu_rdata), 32'h41);
    tick();

    // CPU read colliding with a scan read: ack one cycle later
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00095;
    scan_req = 1'b1; scan_addr = 20'd5;
    tick();
    scan_req = 1'b0;
    chk("coll no early ack", 32'(cpu_ack), 32'd0);
    tick();
    cpu_req = 1'b0;
    chk("coll ack", 32'(cpu_ack), 32'd1);
    chk("coll rdata", 32'(cpu_rdata), 32'h41);
    chk("coll scan data", 32'(scan_data), 32'd5);
    tick();

    // Out-of-range accesses: acked, no RAM effect, read returns zero
    do_load(2'd3);
    w0 = wr_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'd2400; cpu_wdata = 8'hEE;
    @(negedge clk_25mhz);
    chk("oor wr we", 32'(ram_we), 32'd0);
    tick();
    cpu_req = 1'b0;
    chk("oor wr ack", 32'(cpu_ack), 32'd1);
    tick();
    chk("oor wr no write", 32'(wr_cnt - w0), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'd4095;
    tick();
    cpu_req = 1'b0;
    chk("oor rd ack", 32'(cpu_ack), 32'd1);
    chk("oor rd data", 32'(cpu_rdata), 32'd0);
    tick();

    // Scroll with no scan traffic
    do_load(2'd2);
    take_snap();
    scroll_start = 1'b1;
    tick();
    scroll_start = 1'b0;
    chk("s1 busy rise", 32'(scroll_busy), 32'd1);
    watch_scroll(1'b0, bc, st, ak);
    chk("s1 busy cycles", 32'(bc), 32'd4720);
    chk("s1 done", 32'(scroll_done), 32'd1);
    tick();
    chk("s1 done one pulse", 32'(scroll_done), 32'd0);
    check_image("s1 image");
    chk("s1 row0", 32'(mem[0]), 32'd1);
    chk("s1 row15", 32'(mem[1200]), 32'd16);
    chk("s1 row28 end", 32'(mem[2319]), 32'd29);
    chk("s1 row29 end", 32'(mem[2399]), 32'h20);

    // Scroll under scan traffic with the CPU waiting; first CPU request coincides with start
    do_load(2'd2);
    take_snap();
    scroll_start = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'd85;
    @(negedge clk_25mhz);
    chk("s2 cpu granted with start", 32'(ram_addr), 32'd85);
    tick();
    scroll_start = 1'b0;
    chk("s2 busy rise", 32'(scroll_busy), 32'd1);
    chk("s2 first ack", 32'(cpu_ack), 32'd1);
    chk("s2 first rdata", 32'(cpu_rdata), 32'd1);
    cpu_addr = 20'd0;
    watch_scroll(1'b1, bc, st, ak);
    chk("s2 busy minus stolen", 32'(bc - st), 32'd4720);
    chk("s2 acks while busy", 32'(ak), 32'd0);
    chk("s2 done", 32'(scroll_done), 32'd1);
    tick();
    cpu_req = 1'b0;
    chk("s2 ack after busy", 32'(cpu_ack), 32'd1);
    chk("s2 ack rdata", 32'(cpu_rdata), 32'd1);
    tick();
    check_image("s2 image");

    // Reset in the middle of a scroll
    do_load(2'd2);
    scroll_start = 1'b1;
    tick();
    scroll_start = 1'b0;
    repeat (999) tick();
    chk("r busy before", 32'(scroll_busy), 32'd1);
    clrn = 1'b0;
    #1;
    chk("r busy drop", 32'(scroll_busy), 32'd0);
    chk("r we drop", 32'(ram_we), 32'd0);
    chk("r no done", 32'(scroll_done), 32'd0);
    repeat (2) tick();
    @(negedge clk_25mhz);
    clrn = 1'b1;
    repeat (4) tick();
    chk("r idle busy", 32'(scroll_busy), 32'd0);
    chk("r idle done", 32'(scroll_done), 32'd0);
    take_snap();
    chk("r partial copied", 32'(snap[0]), 32'd1);
    chk("r partial untouched", 32'(snap[2319]), 32'd28);
    scroll_start = 1'b1;
    tick();
    scroll_start = 1'b0;
    chk("r2 busy rise", 32'(scroll_busy), 32'd1);
    watch_scroll(1'b0, bc, st, ak);
    chk("r2 busy cycles", 32'(bc), 32'd4720);
    chk("r2 done", 32'(scroll_done), 32'd1);
    tick();
    check_image("r2 image");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port text-VRAM scheduler that shares one 8-bit character RAM (80×30 cells, address = row*80 + col) among three requesters:
- the VGA scan path, which gets fixed top priority;
- a hardware scroll engine that shifts the screen up one text row and blanks the last row;
- the CPU load/store port.

It sits between the CPU bus interface and the VRAM, and drives the address/data the character renderer consumes on the 25 MHz pixel clock.

## Interface
Parameters:
- COLS, 80, characters per row
- ROWS, 30, text rows
- AW, 20, VRAM address width
- FILL_CHAR, 8'h20, character written into the vacated bottom row

Ports:
- clk_25mhz  in  1  pixel/system clock; all logic on the rising edge
- clrn  in  1  asynchronous, active-low reset
- scan_req  in  1  scan path needs a character this cycle
- scan_addr  in  AW  scan cell address
- scan_data  out  8  character for the last granted scan read
- cpu_req  in  1  CPU access request; held until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU cell address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid while cpu_ack = 1
- scroll_start  in  1  one-cycle pulse that starts a scroll-up
- scroll_busy  out  1  scroll in progress
- scroll_done  out  1  one-cycle pulse after the last fill write
- ram_addr  out  AW  VRAM address (combinational from the grant)
- ram_we  out  1  VRAM write enable
- ram_wdata  out  8  VRAM write data
- ram_rdata  in  8  VRAM synchronous read data, 1-cycle latency

## Operation
- Fixed priority per cycle: scan > scroll engine > CPU. Exactly one grant or none per cycle.
- Scan read: when scan_req = 1, ram_addr = scan_addr and ram_we = 0. ram_rdata is registered into scan_data at the end of the next cycle. scan_data otherwise holds its value.
- CPU access:
  - The CPU is granted only when scan_req = 0, scroll_busy = 0 and cpu_ack = 0. The ack cycle is never a grant cycle.
  - Write: ram_we = 1 in the grant cycle.
  - Read: ram_rdata is captured in the following cycle.
  - cpu_ack goes to 1 in the cycle after the grant. cpu_rdata is valid in that cycle.
  - cpu_addr ≥ COLS*ROWS (2400): no RAM access and ram_we = 0; cpu_rdata = 8'h00; still acked with the same timing.
- Scroll engine FSM:
  - IDLE: scroll_start → COPY_RD with idx = 0. scroll_start is ignored when not in IDLE.
  - COPY_RD: read idx+COLS when granted → COPY_WR.
  - COPY_WR: write idx when granted. Write data is ram_rdata if the read was granted in the previous cycle, else the hold register. The hold register captures ram_rdata in the cycle after every engine read. Then idx+1. When idx = COLS*(ROWS-1)-1 (2319) has been written → FILL with idx = 2320, else → COPY_RD.
  - FILL: write FILL_CHAR to idx when granted. After idx = 2399 → DONE.
  - DONE: pulse scroll_done for one cycle → IDLE.
  - A stolen slot (scan_req = 1) leaves the state and idx unchanged.
- scroll_busy = 1 in COPY_RD, COPY_WR and FILL.
- scroll_start and cpu_req in the same cycle: the CPU is granted this cycle if free. Busy starts the next cycle, so any pending CPU request waits.
- Reset mid-scroll: the scroll is aborted and the FSM returns to IDLE. The partial scroll is left in VRAM. No done pulse.

## Timing
- Reset values:
  - scan_data = 0, cpu_ack = 0, cpu_rdata = 0
  - scroll_busy = 0, scroll_done = 0
  - ram_we = 0, ram_addr = 0, ram_wdata = 0 while clrn = 0
- Scan latency: request in cycle t, scan_data updated at edge t+2. The renderer prefetches accordingly.
- CPU latency: grant in cycle t, ack in t+1. Minimum 2 cycles per CPU access.
- Scroll with no scan traffic: busy rises one cycle after start, lasts 2320*2 + 80 = 4720 cycles, then done is pulsed.
- Each scan-stolen cycle adds exactly one cycle to the scroll duration.

## Structure
- Shared package vram_pkg holds:
  - COLS, ROWS
  - CELLS = 2400
  - COPY_CELLS = 2320
  - FILL_CHAR
  - VRAM_AW
  - the scroll-state enum (IDLE, COPY_RD, COPY_WR, FILL, DONE)
- Sub-module vram_scroll_engine contains the FSM, idx counter and hold register. It exposes req/we/addr/wdata/granted to the top. The top contains the priority mux, CPU ack logic and scan capture.

## Test plan
- Scan only: scan_req every 8 cycles over addresses 0..79 of a preloaded RAM (cell i = i[7:0]). Required: scan_data = i at edge t+2 for each request; no writes.
- CPU write then read:
  - write 8'h41 to 0x00095 → ack exactly 1 cycle after grant, no ack-cycle regrant;
  - read 0x00095 → cpu_rdata = 8'h41 with ack.
  - Request coincident with scan_req: ack delayed by exactly one cycle.
- CPU out-of-range: write to 2400 → ram_we stays 0, ack given; read to 4095 → cpu_rdata = 8'h00.
- Scroll with no scan traffic: RAM cell = row number. Required: busy for 4720 cycles, then one done pulse. Afterwards rows 0..28 hold 1..29 and row 29 is all 8'h20.
- Scroll under a scan every 8 cycles, with cpu_req held high: same final image; duration = 4720 + stolen cycles; no CPU ack until the cycle after busy falls.
- Reset mid-scroll: assert clrn = 0 at cycle 1000. Required: busy = 0 and ram_we = 0 immediately; after release, IDLE; a new scroll_start completes normally.
